// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display driver: the scan-state enum,
// the active-low segment table and the "all off" pin constants.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low, for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational 4-bit digit to active-low seven-segment decoder. Values 10..15
// display as hex letters.
import seg_pkg::*;

module bcd_to_seg (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[bcd_i];

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit time-multiplexed seven-segment driver with per-slot blanking.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits above DP_DIGIT.
import seg_pkg::*;

module seg_display_mux #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int DP_DIGIT     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [6:0] seg,
    output logic       decimal,
    output logic [3:0] an
);

    localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_e      state_q, state_d;
    logic [3:0]       snap_q [4];
    logic [3:0]       snap_d [4];
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dec_q, dec_d;

    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic             suppress;

    assign cur_digit = snap_q[idx_q];

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        state_d  = state_q;
        snap_d   = snap_q;
        suppress = 1'b0;
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        dec_d    = 1'b1;

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end else if (cnt_d == CNT_BLANK) begin
            state_d = DRIVE;
        end

        // Whole frame is captured at once so a digit roll-over cannot tear mid-scan.
        if (idx_q == 2'd0 && cnt_q == '0) begin
            snap_d = '{d0, d1, d2, d3};
        end

`ifdef LEADING_ZERO_BLANK_EN
        if (int'(idx_q) > DP_DIGIT) begin
            suppress = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (j >= int'(idx_q) && snap_q[j] != 4'd0) begin
                    suppress = 1'b0;
                end
            end
        end
`endif

        if (state_q == DRIVE && !suppress) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = cur_seg;
            dec_d = (int'(idx_q) == DP_DIGIT) ? 1'b0 : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            // With blanking disabled a slot begins directly in DRIVE.
            state_q <= (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            // NOTE: the snapshot is four plain registers with a defined reset value, not a RAM, so resetting it is cheap and intended.
            snap_q  <= '{default: 4'd0};
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dec_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dec_q   <= dec_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign decimal = dec_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: expected pin values per cycle are queued
// when a frame starts and compared on the falling edge.
module tb_seg_display_mux;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int DP_DIGIT     = 2;

    localparam logic [6:0] DEC_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dec;
    } pins_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] d0, d1, d2, d3;
    logic [6:0] seg;
    logic       decimal;
    logic [3:0] an;

    pins_t      exp_q [$];
    pins_t      exp_e;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         lz_en;

    always #5 clk = ~clk;

    seg_display_mux #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DP_DIGIT     (DP_DIGIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .seg     (seg),
        .decimal (decimal),
        .an      (an)
    );

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("an",      {3'b000, an},       {3'b000, exp_e.an});
            check("seg",     seg,                exp_e.seg);
            check("decimal", {6'b000000, decimal}, {6'b000000, exp_e.dec});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [15:0] cur_digits();
        return {d3, d2, d1, d0};
    endfunction

    task automatic push_off();
        pins_t p;
        p.an  = 4'hF;
        p.seg = 7'h7F;
        p.dec = 1'b1;
        exp_q.push_back(p);
    endtask

    // One slot as seen on the pins: BLANK_CYCLES off, then n_drive cycles of digit k.
    task automatic push_slot(input int k, input logic [15:0] s, input int n_drive);
        pins_t      p;
        logic [15:0] upper;
        logic [3:0] dig;
        bit         hide;
        upper = s >> (4 * k);
        dig   = upper[3:0];
        hide  = lz_en && (k > DP_DIGIT) && (upper == 16'h0000);
        repeat (BLANK_CYCLES) push_off();
        for (int i = 0; i < n_drive; i++) begin
            if (hide) begin
                push_off();
            end else begin
                p.an  = ~(4'b0001 << k);
                p.seg = DEC_TAB[dig];
                p.dec = (k == DP_DIGIT) ? 1'b0 : 1'b1;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic push_frame(input logic [15:0] s);
        for (int k = 0; k < 4; k++) push_slot(k, s, SCAN_DIV - BLANK_CYCLES);
    endtask

    initial begin
        logic [15:0] snap;
`ifdef LEADING_ZERO_BLANK_EN
        lz_en = 1'b1;
`else
        lz_en = 1'b0;
`endif
        {d3, d2, d1, d0} = 16'h1234;
        reset = 1'b0;

        // Pins held off through reset.
        repeat (3) begin
            tick();
            push_off();
        end
        reset = 1'b1;

        // Frame 1: digits 1,2,3,4; d0 changes mid-frame and must not show yet.
        tick();
        push_frame(cur_digits());
        run(11);
        d0 = 4'h7;
        run(20);

        // Frame 2: d0=7 now visible; hex digits applied mid-frame.
        tick();
        push_frame(cur_digits());
        run(10);
        {d3, d2, d1, d0} = 16'hFCBA;
        run(21);

        // Frame 3: A,b,C,F on an=E,D,B,7.
        tick();
        push_frame(cur_digits());
        run(10);
        {d3, d2, d1, d0} = 16'h0059;
        run(21);

        // Frame 4: leading zeros in digits 3 and 2.
        tick();
        push_frame(cur_digits());
        run(31);

        // Frame 5: reset pulse while digit 2 is driven.
        tick();
        snap = cur_digits();
        push_slot(0, snap, SCAN_DIV - BLANK_CYCLES);
        push_slot(1, snap, SCAN_DIV - BLANK_CYCLES);
        push_slot(2, snap, 2);
        run(19);
        reset = 1'b0;
        tick();
        push_off();
        reset = 1'b1;

        // Scanning restarts at digit 0 with a full 32-cycle frame.
        tick();
        push_frame(cur_digits());
        run(31);
        {d3, d2, d1, d0} = 16'h8016;
        tick();
        push_frame(cur_digits());
        run(31);

        @(negedge clk);
        #1;
        check("queue_drained", 7'(exp_q.size()), 7'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Time-multiplexed driver for the four-digit seven-segment display on the stopwatch top level. It consumes the four digits produced by the stopwatch counter (d0 = least significant) and drives the cathode, decimal-point and anode pins. Each frame it snapshots the digits and scans them one at a time, with a blanking gap at every digit change to prevent ghosting.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 2000: cycles at the start of each slot with all anodes off; 0 disables blanking.
- DP_DIGIT, 2: index (0-3) of the digit whose decimal point is lit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- d0, d1, d2, d3  in  4 each  digit values; d0 is least significant
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- decimal  out  1  decimal-point cathode, active-low
- an  out  4  anodes, active-low; an[k] selects digit k

## Operation
- Internal state:
  - slot counter cnt, 0..SCAN_DIV-1
  - digit index idx, 2 bits
  - FSM {BLANK, DRIVE}
  - snapshot registers s0..s3
- Slot sequence:
  - A slot starts in BLANK with cnt=0.
  - When cnt reaches BLANK_CYCLES, the FSM moves to DRIVE. If BLANK_CYCLES=0, the slot starts directly in DRIVE and BLANK is never entered.
  - At cnt=SCAN_DIV-1: cnt wraps to 0, idx increments modulo 4 (3 wraps to 0), and the FSM returns to BLANK.
- Snapshot: s0..s3 load d0..d3 in the first cycle of every frame (idx=0, cnt=0). Input changes during a frame have no effect until the next frame.
- Pins in BLANK: an=4'b1111, seg=7'h7F, decimal=1.
- Pins in DRIVE for digit k:
  - an has only bit k low.
  - seg = decode(sk).
  - decimal = 0 iff k==DP_DIGIT.
- Decode table (hex): 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E. Values 10-15 display as hex; no error flag.
- Reset (reset=0 at a clock edge):
  - cnt=0, idx=0, FSM=BLANK, s0..s3=0.
  - an=4'b1111, seg=7'h7F, decimal=1.
  - Reset mid-frame aborts the scan immediately. Scanning resumes from digit 0 in BLANK, and the snapshot loads on the first edge after reset returns high.

## Timing
- an, seg and decimal are registered.
- Pin latency: the pins reflect the (FSM, idx, snapshot) state of the previous cycle, so 1 cycle.
- Digit k's anode is low for SCAN_DIV-BLANK_CYCLES consecutive cycles per frame.
- Frame length: exactly 4*SCAN_DIV cycles.
- Refresh rate at defaults with a 100 MHz clock: 250 Hz per digit.
- Widths: cnt is $clog2(SCAN_DIV) bits; no other arithmetic.
- Simultaneous input change and snapshot cycle: the value present at that edge is captured.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit k with k>DP_DIGIT is suppressed when sj==0 for all j>=k.
  - A suppressed digit behaves as BLANK for its whole slot: anode off, seg=7'h7F, decimal=1. Slot timing is unchanged.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always driven, including leading zeros.

## Structure
- Shared package seg_pkg holds:
  - the scan state enum (BLANK, DRIVE)
  - the 16-entry active-low segment constant table
  - constants SEG_OFF=7'h7F and AN_OFF=4'hF
- Sub-module bcd_to_seg: purely combinational 4-bit to 7-bit decoder built from the seg_pkg table. It is instantiated once, fed by the selected snapshot digit.
- All other logic (counter, FSM, snapshot, output registers) lives in seg_display_mux.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYCLES=2, DP_DIGIT=2.
- Reset low then release, with d3..d0=1,2,3,4:
  - Pins hold an=F, seg=7F, decimal=1 through reset.
  - In the first frame an reads F,F, then E for 6 cycles with seg=19, then F,F, then D for 6 cycles with seg=30.
  - Digit 2 shows seg=24 with decimal=0.
  - Digit 3 shows seg=79.
- Change d0 from 4 to 7 mid-frame: digit 0 keeps seg=19 until the next frame, then shows seg=78.
- Apply d0..d3=A,B,C,F: seg shows 08, 03, 46, 0E on an=E, D, B, 7 respectively.
- Assert reset for one cycle while digit 2 is driven: next cycle an=F. Scanning restarts at digit 0 after 2 blank cycles; frame length is 32 cycles from release.
- With LEADING_ZERO_BLANK_EN defined and d3..d0=0,0,5,9:
  - Digit 3 slot is an=F for all 8 cycles.
  - Digit 2 shows seg=40 with decimal=0.
- Same stimulus without LEADING_ZERO_BLANK_EN: digit 3 shows an=7, seg=40.
